// File: rtl/control_pkg.sv
// Shared encodings for the accumulator-machine control sequencer: opcodes, FSM states,
// datapath mux selects and the opcode to ALU-operation mapping.
package control_pkg;

  localparam logic [3:0] OpHalt    = 4'h0;
  localparam logic [3:0] OpLoad    = 4'h1;
  localparam logic [3:0] OpStore   = 4'h2;
  localparam logic [3:0] OpAdd     = 4'h3;
  localparam logic [3:0] OpSub     = 4'h4;
  localparam logic [3:0] OpAnd     = 4'h5;
  localparam logic [3:0] OpOr      = 4'h6;
  localparam logic [3:0] OpXor     = 4'h7;
  localparam logic [3:0] OpJump    = 4'h8;
  localparam logic [3:0] OpJz      = 4'h9;
  localparam logic [3:0] OpShl     = 4'hA;
  localparam logic [3:0] OpShr     = 4'hB;
  localparam logic [3:0] OpClear   = 4'hC;
  localparam logic [3:0] OpLoadi   = 4'hD;
  localparam logic [3:0] OpNop     = 4'hE;
  localparam logic [3:0] OpIllegal = 4'hF;

  typedef enum logic [3:0] {
    StIdle       = 4'd0,
    StFetchAddr  = 4'd1,
    StFetchRead  = 4'd2,
    StFetchIr    = 4'd3,
    StDecode     = 4'd4,
    StMemRead    = 4'd5,
    StMemCapture = 4'd6,
    StExecute    = 4'd7,
    StStoreWrite = 4'd8,
    StHalt       = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    ClsMem,
    ClsStore,
    ClsJump,
    ClsJz,
    ClsAccOp,
    ClsNop,
    ClsHalt,
    ClsIllegal
  } instr_class_e;

  localparam logic PcSelInc      = 1'b0;
  localparam logic PcSelOperand  = 1'b1;
  localparam logic MarSelPc      = 1'b0;
  localparam logic MarSelOperand = 1'b1;
  localparam logic MbrSelMem     = 1'b0;
  localparam logic MbrSelAcc     = 1'b1;

  localparam logic [1:0] AccSelAlu  = 2'd0;
  localparam logic [1:0] AccSelMbr  = 2'd1;
  localparam logic [1:0] AccSelImm  = 2'd2;
  localparam logic [1:0] AccSelZero = 2'd3;

  // Opcodes that do not use the ALU map to 0000.
  function automatic logic [3:0] alu_op_of(input logic [3:0] opcode);
    logic [3:0] op;
    case (opcode)
      OpAdd:   op = 4'b0000;
      OpSub:   op = 4'b0001;
      OpAnd:   op = 4'b1000;
      OpOr:    op = 4'b1001;
      OpXor:   op = 4'b1010;
      OpShl:   op = 4'b0100;
      OpShr:   op = 4'b0101;
      default: op = 4'b0000;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath/memory side (slave).
interface control_sequencer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 16
);
  logic              start;
  logic [ADDR_W+3:0] ir;
  logic              acc_zero;
  logic              pc_write;
  logic              pc_sel;
  logic              mar_write;
  logic              mar_sel;
  logic              mbr_write;
  logic              mbr_sel;
  logic              ir_write;
  logic              acc_write;
  logic [1:0]        acc_sel;
  logic [3:0]        alu_op;
  logic              mem_write_enable;
  logic              halted;
  logic              illegal;
  logic [3:0]        state;
  logic [CNT_W-1:0]  retired;

  modport master (
    input  start, ir, acc_zero,
    output pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel, ir_write, acc_write,
           acc_sel, alu_op, mem_write_enable, halted, illegal, state, retired
  );

  modport slave (
    output start, ir, acc_zero,
    input  pc_write, pc_sel, mar_write, mar_sel, mbr_write, mbr_sel, ir_write, acc_write,
           acc_sel, alu_op, mem_write_enable, halted, illegal, state, retired
  );
endinterface

// File: rtl/control_decode.sv
// Combinational opcode decoder: instruction class, ALU operation and ACC source select.
module control_decode
  import control_pkg::*;
(
  input  logic [3:0]   opcode_i,
  output instr_class_e iclass_o,
  output logic [3:0]   alu_op_o,
  output logic [1:0]   acc_sel_o
);

  always_comb begin
    iclass_o  = ClsNop;
    acc_sel_o = AccSelAlu;
    alu_op_o  = alu_op_of(opcode_i);
    unique case (opcode_i)
      OpHalt:    iclass_o = ClsHalt;
      OpLoad: begin
        iclass_o  = ClsMem;
        acc_sel_o = AccSelMbr;
      end
      OpStore:   iclass_o = ClsStore;
      OpAdd, OpSub, OpAnd, OpOr, OpXor: iclass_o = ClsMem;
      OpJump:    iclass_o = ClsJump;
      OpJz:      iclass_o = ClsJz;
      OpShl, OpShr: iclass_o = ClsAccOp;
      OpClear: begin
        iclass_o  = ClsAccOp;
        acc_sel_o = AccSelZero;
      end
      OpLoadi: begin
        iclass_o  = ClsAccOp;
        acc_sel_o = AccSelImm;
      end
      OpNop:     iclass_o = ClsNop;
      OpIllegal: iclass_o = ClsIllegal;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit accumulator machine.
// Owns the FSM, the sticky illegal flag and the retired-instruction counter.
module control_sequencer
  import control_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  control_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  logic [3:0]   opcode;
  instr_class_e dec_class;
  logic [3:0]   dec_alu_op;
  logic [1:0]   dec_acc_sel;

  assign opcode = bus.ir[ADDR_W +: 4];

  control_decode u_decode (
    .opcode_i  (opcode),
    .iclass_o  (dec_class),
    .alu_op_o  (dec_alu_op),
    .acc_sel_o (dec_acc_sel)
  );

  always_comb begin
    state_d              = state_q;
    illegal_d            = illegal_q;
    retire               = 1'b0;
    bus.pc_write         = 1'b0;
    bus.pc_sel           = PcSelInc;
    bus.mar_write        = 1'b0;
    bus.mar_sel          = MarSelPc;
    bus.mbr_write        = 1'b0;
    bus.mbr_sel          = MbrSelMem;
    bus.ir_write         = 1'b0;
    bus.acc_write        = 1'b0;
    bus.acc_sel          = AccSelAlu;
    bus.alu_op           = 4'b0000;
    bus.mem_write_enable = 1'b0;
    bus.halted           = 1'b0;

    unique case (state_q)
      StIdle:      if (bus.start) state_d = StFetchAddr;
      StFetchAddr: begin
        bus.mar_write = 1'b1;
        state_d       = StFetchRead;
      end
      StFetchRead: state_d = StFetchIr;
      StFetchIr: begin
        bus.ir_write = 1'b1;
        bus.pc_write = 1'b1;
        state_d      = StDecode;
      end
      StDecode: begin
        state_d = StFetchAddr;
        unique case (dec_class)
          ClsMem: begin
            bus.mar_write = 1'b1;
            bus.mar_sel   = MarSelOperand;
            state_d       = StMemRead;
          end
          ClsStore: begin
            bus.mar_write = 1'b1;
            bus.mar_sel   = MarSelOperand;
            bus.mbr_write = 1'b1;
            bus.mbr_sel   = MbrSelAcc;
            state_d       = StStoreWrite;
          end
          ClsJump: begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = PcSelOperand;
            retire       = 1'b1;
          end
          ClsJz: begin
            bus.pc_write = bus.acc_zero;
            bus.pc_sel   = bus.acc_zero ? PcSelOperand : PcSelInc;
            retire       = 1'b1;
          end
          ClsAccOp: begin
            bus.acc_write = 1'b1;
            bus.acc_sel   = dec_acc_sel;
            bus.alu_op    = dec_alu_op;
            retire        = 1'b1;
          end
          ClsNop:  retire = 1'b1;
          ClsHalt: begin
            retire  = 1'b1;
            state_d = StHalt;
          end
          ClsIllegal: begin
            illegal_d = 1'b1;
            state_d   = StHalt;
          end
        endcase
      end
      StMemRead: state_d = StMemCapture;
      StMemCapture: begin
        bus.mbr_write = 1'b1;
        bus.mbr_sel   = MbrSelMem;
        state_d       = StExecute;
      end
      StExecute: begin
        bus.acc_write = 1'b1;
        bus.acc_sel   = dec_acc_sel;
        bus.alu_op    = dec_alu_op;
        retire        = 1'b1;
        state_d       = StFetchAddr;
      end
      StStoreWrite: begin
        // A reset landing on this cycle abandons the write.
        bus.mem_write_enable = ~reset;
        retire               = 1'b1;
        state_d              = StFetchAddr;
      end
      StHalt:  bus.halted = 1'b1;
      default: state_d = StIdle;
    endcase

    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a behavioural datapath/memory executes the strobes, a
// per-opcode vector table plus hand-written sequences check cycle counts and results.
module tb_control_sequencer;

  // Narrow counter keeps the wrap-around run short.
  localparam int unsigned CW = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_sequencer_if #(.ADDR_W(12), .CNT_W(CW)) bus ();

  control_sequencer #(.ADDR_W(12), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural datapath and synchronous memory.
  logic [15:0] mem  [4096];
  logic [15:0] prog [4096];
  logic [11:0] pc, mar;
  logic [15:0] mbr, ir_r, acc, dout;
  logic [15:0] acc_init = 16'h0;
  logic        dp_init = 1'b1;

  assign bus.ir       = ir_r;
  assign bus.acc_zero = (acc == 16'h0);

  function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a,
                                      input logic [15:0] b);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return a ^ b;
      4'b0100: return a << 1;
      4'b0101: return a >> 1;
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk) begin
    if (dp_init) begin
      mem  <= prog;
      pc   <= 12'h0;
      mar  <= 12'h0;
      mbr  <= 16'h0;
      ir_r <= 16'h0;
      dout <= 16'h0;
      acc  <= acc_init;
    end else begin
      dout <= mem[mar];
      if (bus.pc_write)  pc  <= bus.pc_sel ? bus.ir[11:0] : pc + 12'd1;
      if (bus.mar_write) mar <= bus.mar_sel ? bus.ir[11:0] : pc;
      if (bus.mbr_write) mbr <= bus.mbr_sel ? acc : dout;
      if (bus.ir_write)  ir_r <= dout;
      if (bus.acc_write) begin
        case (bus.acc_sel)
          2'd0:    acc <= alu(bus.alu_op, acc, mbr);
          2'd1:    acc <= mbr;
          2'd2:    acc <= {4'h0, bus.ir[11:0]};
          default: acc <= 16'h0;
        endcase
      end
      if (bus.mem_write_enable) mem[mar] <= mbr;
    end
  end

  // Strobe vector: {pcw,pcs,marw,mars,mbrw,mbrs,irw,accw,acc_sel[1:0],alu_op[3:0],mwe,halted}
  logic [15:0] act_vec;
  assign act_vec = {bus.pc_write, bus.pc_sel, bus.mar_write, bus.mar_sel, bus.mbr_write,
                    bus.mbr_sel, bus.ir_write, bus.acc_write, bus.acc_sel, bus.alu_op,
                    bus.mem_write_enable, bus.halted};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected DECODE strobe vectors queued at stimulus time.
  logic [15:0] sb_q[$];
  logic        sb_en = 1'b0;
  logic [15:0] sb_exp;

  always @(negedge clk) begin
    if (sb_en && bus.state == 4'd4) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_underflow: DECODE seen with strobes %h, nothing expected", act_vec);
      end else begin
        sb_exp = sb_q.pop_front();
        check("decode_strobes", {16'h0, act_vec}, {16'h0, sb_exp});
      end
    end
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] acc0;
    logic [15:0] dec;
    logic [15:0] acc_exp;
    logic [11:0] pc_exp;
    int          cycles;
    logic        halt;
    logic        ill;
  } vec_t;

  vec_t vt[17];

  task automatic clear_prog();
    for (int i = 0; i < 4096; i++) prog[i] = 16'h0;
  endtask

  // Called and returns at a negedge; resets DUT and reloads the datapath model.
  task automatic do_reset(input logic [15:0] a0);
    acc_init = a0;
    reset    = 1'b1;
    dp_init  = 1'b1;
    repeat (2) @(negedge clk);
    reset   = 1'b0;
    dp_init = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  logic [15:0] ev[7];
  int n;

  initial begin
    bus.start = 1'b0;
    vt[0]  = '{16'h1100, 16'h0011, 16'h3000, 16'h0003, 12'h001, 7, 1'b0, 1'b0};
    vt[1]  = '{16'h3100, 16'h0005, 16'h3000, 16'h0008, 12'h001, 7, 1'b0, 1'b0};
    vt[2]  = '{16'h4100, 16'h0005, 16'h3000, 16'h0002, 12'h001, 7, 1'b0, 1'b0};
    vt[3]  = '{16'h5100, 16'h0006, 16'h3000, 16'h0002, 12'h001, 7, 1'b0, 1'b0};
    vt[4]  = '{16'h6100, 16'h0004, 16'h3000, 16'h0007, 12'h001, 7, 1'b0, 1'b0};
    vt[5]  = '{16'h7100, 16'h0006, 16'h3000, 16'h0005, 12'h001, 7, 1'b0, 1'b0};
    vt[6]  = '{16'h2102, 16'h1234, 16'h3C00, 16'h1234, 12'h001, 5, 1'b0, 1'b0};
    vt[7]  = '{16'h8020, 16'h0000, 16'hC000, 16'h0000, 12'h020, 4, 1'b0, 1'b0};
    vt[8]  = '{16'h9030, 16'h0000, 16'hC000, 16'h0000, 12'h030, 4, 1'b0, 1'b0};
    vt[9]  = '{16'h9030, 16'h0005, 16'h0000, 16'h0005, 12'h001, 4, 1'b0, 1'b0};
    vt[10] = '{16'hA000, 16'h8003, 16'h0110, 16'h0006, 12'h001, 4, 1'b0, 1'b0};
    vt[11] = '{16'hB000, 16'h8003, 16'h0114, 16'h4001, 12'h001, 4, 1'b0, 1'b0};
    vt[12] = '{16'hC000, 16'h1234, 16'h01C0, 16'h0000, 12'h001, 4, 1'b0, 1'b0};
    vt[13] = '{16'hDABC, 16'h1234, 16'h0180, 16'h0ABC, 12'h001, 4, 1'b0, 1'b0};
    vt[14] = '{16'hE000, 16'h0042, 16'h0000, 16'h0042, 12'h001, 4, 1'b0, 1'b0};
    vt[15] = '{16'h0000, 16'h0042, 16'h0000, 16'h0042, 12'h001, 4, 1'b1, 1'b0};
    vt[16] = '{16'hF000, 16'h0042, 16'h0000, 16'h0042, 12'h001, 4, 1'b1, 1'b1};

    @(negedge clk);
    clear_prog();
    do_reset(16'h0);
    check("reset_state", {28'h0, bus.state}, 32'd0);
    check("reset_strobes", {16'h0, act_vec}, 32'h0);
    check("reset_illegal", {31'h0, bus.illegal}, 32'd0);
    check("reset_retired", {20'h0, bus.retired}, 32'd0);

    // Per-opcode vectors.
    sb_en = 1'b1;
    for (int v = 0; v < 17; v++) begin
      clear_prog();
      prog[0]     = vt[v].instr;
      prog[1]     = 16'hE000;
      prog[12'h100] = 16'h0003;
      do_reset(vt[v].acc0);
      sb_q.push_back(vt[v].dec);
      pulse_start();
      n = 1;
      while (n < 20) begin
        @(negedge clk);
        n++;
        if (bus.state == 4'd1 || bus.state == 4'd9) break;
      end
      check($sformatf("v%0d_cycles", v), n - 1, vt[v].cycles);
      check($sformatf("v%0d_retired", v), {20'h0, bus.retired}, vt[v].ill ? 32'd0 : 32'd1);
      check($sformatf("v%0d_illegal", v), {31'h0, bus.illegal}, {31'h0, vt[v].ill});
      check($sformatf("v%0d_halted", v), {31'h0, bus.halted}, {31'h0, vt[v].halt});
      check($sformatf("v%0d_acc", v), {16'h0, acc}, {16'h0, vt[v].acc_exp});
      check($sformatf("v%0d_pc", v), {20'h0, pc}, {20'h0, vt[v].pc_exp});
    end
    sb_en = 1'b0;
    check("sb_drain_vectors", sb_q.size(), 32'd0);

    // Four-instruction program: LOADI 5; ADD [0x100]; STORE [0x101]; HALT.
    clear_prog();
    prog[0] = 16'hD005; prog[1] = 16'h3100; prog[2] = 16'h2101; prog[3] = 16'h0000;
    prog[12'h100] = 16'h0003;
    do_reset(16'h0);
    sb_q.push_back(16'h0180);
    sb_q.push_back(16'h3000);
    sb_q.push_back(16'h3C00);
    sb_q.push_back(16'h0000);
    sb_en = 1'b1;
    pulse_start();
    repeat (19) @(negedge clk);
    check("prog_halted_c19", {31'h0, bus.halted}, 32'd0);
    @(negedge clk);
    check("prog_halted_c20", {31'h0, bus.halted}, 32'd1);
    check("prog_state", {28'h0, bus.state}, 32'd9);
    check("prog_retired", {20'h0, bus.retired}, 32'd4);
    check("prog_mem101", {16'h0, mem[12'h101]}, 32'h0008);
    sb_en = 1'b0;
    check("sb_drain_prog", sb_q.size(), 32'd0);

    // CLEAR; JZ 0x010 -> taken.
    clear_prog();
    prog[0] = 16'hC000; prog[1] = 16'h9010;
    do_reset(16'h0055);
    pulse_start();
    repeat (8) @(negedge clk);
    check("jz_taken_retired", {20'h0, bus.retired}, 32'd2);
    @(negedge clk);
    check("jz_taken_mar", {20'h0, mar}, 32'h010);

    // LOADI 1; JZ 0x010 -> falls through.
    clear_prog();
    prog[0] = 16'hD001; prog[1] = 16'h9010; prog[2] = 16'hE000;
    do_reset(16'h0);
    pulse_start();
    repeat (8) @(negedge clk);
    check("jz_fall_retired", {20'h0, bus.retired}, 32'd2);
    @(negedge clk);
    check("jz_fall_mar", {20'h0, mar}, 32'h002);
    check("jz_fall_acc", {16'h0, acc}, 32'h0001);

    // Illegal opcode halts, sets the sticky flag, ignores later starts.
    clear_prog();
    prog[0] = 16'hF000;
    do_reset(16'h0042);
    pulse_start();
    repeat (3) @(negedge clk);
    check("ill_decode_state", {28'h0, bus.state}, 32'd4);
    check("ill_decode_strobes", {16'h0, act_vec}, 32'h0);
    @(negedge clk);
    check("ill_state", {28'h0, bus.state}, 32'd9);
    check("ill_flag", {31'h0, bus.illegal}, 32'd1);
    check("ill_retired", {20'h0, bus.retired}, 32'd0);
    pulse_start();
    pulse_start();
    repeat (2) @(negedge clk);
    check("ill_restart_state", {28'h0, bus.state}, 32'd9);
    check("ill_restart_halted", {31'h0, bus.halted}, 32'd1);
    check("ill_restart_flag", {31'h0, bus.illegal}, 32'd1);
    check("ill_acc", {16'h0, acc}, 32'h0042);

    // ADD strobes cycle by cycle.
    ev[0] = 16'h2000; ev[1] = 16'h0000; ev[2] = 16'h8200; ev[3] = 16'h3000;
    ev[4] = 16'h0000; ev[5] = 16'h0800; ev[6] = 16'h0100;
    clear_prog();
    prog[0] = 16'h3100; prog[12'h100] = 16'h0003;
    do_reset(16'h0005);
    pulse_start();
    for (int c = 0; c < 7; c++) begin
      check($sformatf("add_c%0d_state", c), {28'h0, bus.state}, c + 1);
      check($sformatf("add_c%0d_strobes", c), {16'h0, act_vec}, {16'h0, ev[c]});
      @(negedge clk);
    end
    check("add_acc", {16'h0, acc}, 32'h0008);

    // Reset during STORE_WRITE abandons the write.
    clear_prog();
    prog[0] = 16'h2101; prog[12'h101] = 16'hBEEF;
    do_reset(16'h1234);
    pulse_start();
    repeat (4) @(negedge clk);
    check("sw_state", {28'h0, bus.state}, 32'd8);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("sw_rst_state", {28'h0, bus.state}, 32'd0);
    check("sw_rst_strobes", {16'h0, act_vec}, 32'h0);
    check("sw_rst_retired", {20'h0, bus.retired}, 32'd0);
    check("sw_rst_mem", {16'h0, mem[12'h101]}, 32'hBEEF);

    // Reset during MEM_CAPTURE after one retired instruction.
    clear_prog();
    prog[0] = 16'hD007; prog[1] = 16'h3100; prog[12'h100] = 16'h0003;
    do_reset(16'h0);
    pulse_start();
    repeat (9) @(negedge clk);
    check("mc_state", {28'h0, bus.state}, 32'd6);
    check("mc_retired", {20'h0, bus.retired}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mc_rst_state", {28'h0, bus.state}, 32'd0);
    check("mc_rst_strobes", {16'h0, act_vec}, 32'h0);
    check("mc_rst_retired", {20'h0, bus.retired}, 32'd0);
    check("mc_rst_illegal", {31'h0, bus.illegal}, 32'd0);

    // JUMP-to-self loop wraps the retired counter.
    clear_prog();
    prog[0] = 16'h8000;
    do_reset(16'h0);
    pulse_start();
    repeat (4 * 4095) @(negedge clk);
    check("wrap_max", {20'h0, bus.retired}, 32'hFFF);
    repeat (4) @(negedge clk);
    check("wrap_zero", {20'h0, bus.retired}, 32'd0);
    check("wrap_state", {28'h0, bus.state}, 32'd1);
    repeat (4) @(negedge clk);
    check("wrap_one", {20'h0, bus.retired}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
